// File: rtl/afifo_wr_ctrl_if.sv
// Upstream valid/ready word channel feeding the dual-clock FIFO write controller.
// The producer drives valid/data; the controller answers with ready.
interface afifo_wr_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/afifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO (wclk domain): pointers, read-pointer sync, full/level/overflow.
// Optional registered almost-full flag enabled by defining AFIFO_WR_ALMOST_FULL_EN.
module afifo_wr_ctrl #(
  parameter int  WIDTH          = 8,
  parameter int  DEPTH          = 16,
  parameter int  ALMOST_FULL_TH = DEPTH - 2,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic             wclk,
  input  logic             wrstn,
  afifo_wr_ctrl_if.slave   up,
  output logic             ram_wen,
  output logic [AW-1:0]    ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic [AW:0]      wptr_gray,
  input  logic [AW:0]      rptr_gray,
  output logic             wfull,
  output logic [AW:0]      wlevel,
  output logic             walmost_full,
  output logic [7:0]       ovf_cnt
);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("afifo_wr_ctrl: DEPTH must be a power of two and at least 4");
  end
  if ((ALMOST_FULL_TH < 1) || (ALMOST_FULL_TH > DEPTH)) begin : g_bad_th
    $error("afifo_wr_ctrl: ALMOST_FULL_TH must lie in 1..DEPTH");
  end

  logic [AW:0] wbin_reg;
  logic [AW:0] wbin_next;
  logic [AW:0] wgray_reg;
  logic [AW:0] wgray_next;
  logic [AW:0] rq1_reg;
  logic [AW:0] rq2_reg;
  logic [AW:0] rbin_sync;
  logic [AW:0] full_cmp;
  logic        wfull_reg;
  logic [7:0]  ovf_cnt_reg;
  logic        accept;

  assign accept     = up.in_valid & ~wfull_reg;
  assign wbin_next  = wbin_reg + {{AW{1'b0}}, accept};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign full_cmp = {~rq2_reg[AW:AW-1], rq2_reg[AW-2:0]};

  genvar gi;
  generate
    for (gi = 0; gi <= AW; gi++) begin : g_gray2bin
      assign rbin_sync[gi] = ^(rq2_reg >> gi);
    end
  endgenerate

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      wbin_reg    <= '0;
      wgray_reg   <= '0;
      rq1_reg     <= '0;
      rq2_reg     <= '0;
      wfull_reg   <= 1'b0;
      ovf_cnt_reg <= '0;
    end else begin
      wbin_reg  <= wbin_next;
      wgray_reg <= wgray_next;
      rq1_reg   <= rptr_gray;
      rq2_reg   <= rq1_reg;
      wfull_reg <= (wgray_next == full_cmp);
      if (up.in_valid && wfull_reg && (ovf_cnt_reg != 8'hFF)) begin
        ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
      end
    end
  end

`ifdef AFIFO_WR_ALMOST_FULL_EN
  logic [AW:0] level_next;
  logic        walmost_full_reg;

  assign level_next = wbin_next - rbin_sync;

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      walmost_full_reg <= 1'b0;
    end else begin
      walmost_full_reg <= (level_next >= (AW+1)'(ALMOST_FULL_TH));
    end
  end

  assign walmost_full = walmost_full_reg;
`else
  assign walmost_full = 1'b0;
`endif

  assign up.in_ready = ~wfull_reg;
  assign ram_wen     = accept;
  assign ram_waddr   = wbin_reg[AW-1:0];
  assign ram_wdata   = up.in_data;
  assign wptr_gray   = wgray_reg;
  assign wfull       = wfull_reg;
  assign wlevel      = wbin_reg - rbin_sync;
  assign ovf_cnt     = ovf_cnt_reg;

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Directed bench for afifo_wr_ctrl (DEPTH=16, WIDTH=8, TH=12) with the read side stubbed via rptr_gray.
module tb_afifo_wr_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef AFIFO_WR_ALMOST_FULL_EN
  localparam bit AF_ON = 1'b1;
`else
  localparam bit AF_ON = 1'b0;
`endif

  logic          wclk = 1'b0;
  logic          wrstn;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   rptr_gray;
  logic          wfull;
  logic [AW:0]   wlevel;
  logic          walmost_full;
  logic [7:0]    ovf_cnt;

  int checks = 0;
  int errors = 0;

  afifo_wr_ctrl_if #(.WIDTH(WIDTH)) bus ();

  afifo_wr_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL_TH(12)) dut (
    .wclk(wclk), .wrstn(wrstn), .up(bus.slave),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .wptr_gray(wptr_gray), .rptr_gray(rptr_gray), .wfull(wfull),
    .wlevel(wlevel), .walmost_full(walmost_full), .ovf_cnt(ovf_cnt)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    bit         valid;
    logic [7:0] data;
    logic [4:0] rptr;
    bit         e_wen;
    logic [3:0] e_waddr;
    bit         e_ready;
    logic [4:0] e_wgray;
    bit         e_full;
    logic [4:0] e_level;
    bit         e_af;
    logic [7:0] e_ovf;
  } vec_t;

  vec_t fill_tbl[20];

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input logic [4:0] r);
    @(negedge wclk);
    bus.in_valid = v;
    bus.in_data  = d;
    rptr_gray    = r;
    #1;
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge wclk);
    bus.in_valid = 1'b0;
    wrstn = 1'b0;
    #1;
    check({tag, "_wptr"}, wptr_gray, 0);
    check({tag, "_level"}, wlevel, 0);
    check({tag, "_full"}, wfull, 0);
    check({tag, "_ovf"}, ovf_cnt, 0);
    check({tag, "_ready"}, bus.in_ready, 1);
    check({tag, "_af"}, walmost_full, 0);
    #2;
    wrstn = 1'b1;
    rptr_gray = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] prev_gray;
    int n;

    for (int i = 0; i < 20; i++) begin
      n = (i < 16) ? i + 1 : 16;
      fill_tbl[i].valid   = 1'b1;
      fill_tbl[i].data    = 8'(i);
      fill_tbl[i].rptr    = 5'd0;
      fill_tbl[i].e_wen   = (i < 16);
      fill_tbl[i].e_waddr = (i < 16) ? 4'(i) : 4'd0;
      fill_tbl[i].e_ready = (i < 16);
      fill_tbl[i].e_wgray = gray(n);
      fill_tbl[i].e_full  = (i >= 15);
      fill_tbl[i].e_level = 5'(n);
      fill_tbl[i].e_af    = AF_ON && (n >= 12);
      fill_tbl[i].e_ovf   = (i > 15) ? 8'(i - 15) : 8'd0;
    end

    wrstn = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    rptr_gray = '0;
    repeat (2) @(posedge wclk);
    #1;
    check("rst_ready", bus.in_ready, 1);
    check("rst_wen", ram_wen, 0);
    check("rst_wptr", wptr_gray, 0);
    check("rst_level", wlevel, 0);
    check("rst_full", wfull, 0);
    check("rst_af", walmost_full, 0);
    check("rst_ovf", ovf_cnt, 0);
    @(negedge wclk);
    wrstn = 1'b1;

    // Fill: 16 accepts, then 4 overflow attempts
    for (int i = 0; i < 20; i++) begin
      drive(fill_tbl[i].valid, fill_tbl[i].data, fill_tbl[i].rptr);
      check($sformatf("fill%0d_wen", i), ram_wen, fill_tbl[i].e_wen);
      check($sformatf("fill%0d_ready", i), bus.in_ready, fill_tbl[i].e_ready);
      if (fill_tbl[i].e_wen) begin
        check($sformatf("fill%0d_waddr", i), ram_waddr, fill_tbl[i].e_waddr);
        check($sformatf("fill%0d_wdata", i), ram_wdata, fill_tbl[i].data);
      end
      tick();
      check($sformatf("fill%0d_wgray", i), wptr_gray, fill_tbl[i].e_wgray);
      check($sformatf("fill%0d_full", i), wfull, fill_tbl[i].e_full);
      check($sformatf("fill%0d_level", i), wlevel, fill_tbl[i].e_level);
      check($sformatf("fill%0d_af", i), walmost_full, fill_tbl[i].e_af);
      check($sformatf("fill%0d_ovf", i), ovf_cnt, fill_tbl[i].e_ovf);
    end

    // Drain release: reader frees one slot
    drive(1'b0, 8'h00, gray(1));
    tick();
    check("drain_e1_level", wlevel, 16);
    check("drain_e1_full", wfull, 1);
    tick();
    check("drain_e2_level", wlevel, 15);
    check("drain_e2_full", wfull, 1);
    tick();
    check("drain_e3_full", wfull, 0);
    drive(1'b1, 8'hA5, gray(1));
    check("drain_wen", ram_wen, 1);
    check("drain_waddr", ram_waddr, 0);
    check("drain_wdata", ram_wdata, 8'hA5);
    check("drain_ready", bus.in_ready, 1);
    tick();
    check("drain_refull", wfull, 1);
    check("drain_wgray", wptr_gray, gray(17));
    check("drain_level", wlevel, 16);
    check("drain_ovf", ovf_cnt, 4);

    // Overflow saturation while held full
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 250) check("ovf_250", ovf_cnt, 254);
      if (k == 251) check("ovf_251", ovf_cnt, 255);
      if (k == 300) begin
        check("ovf_300", ovf_cnt, 255);
        check("ovf_ready", bus.in_ready, 0);
        check("ovf_wen", ram_wen, 0);
      end
    end

    reset_pulse("rst_full");

    // Reset mid-fill after 9 writes
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'(8'h40 + i), 5'd0);
      tick();
    end
    check("mid_level", wlevel, 9);
    check("mid_wgray", wptr_gray, gray(9));
    reset_pulse("rst_mid");
    drive(1'b1, 8'h77, 5'd0);
    check("mid_post_wen", ram_wen, 1);
    check("mid_post_waddr", ram_waddr, 0);
    tick();
    check("mid_post_wgray", wptr_gray, gray(1));

    reset_pulse("rst_wrap");

    // Wrap: reader trails by 4 words, synchronizer adds 2 more cycles
    prev_gray = 5'd0;
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 8'(c), gray((c >= 4) ? c - 4 : 0));
      check($sformatf("wrap%0d_ready", c), bus.in_ready, 1);
      check($sformatf("wrap%0d_waddr", c), ram_waddr, c % 16);
      tick();
      check($sformatf("wrap%0d_wgray", c), wptr_gray, gray(c + 1));
      check($sformatf("wrap%0d_onebit", c), $countones(prev_gray ^ wptr_gray), 1);
      check($sformatf("wrap%0d_lvl_le6", c), (wlevel <= 6), 1);
      prev_gray = wptr_gray;
    end
    drive(1'b0, 8'h00, gray(36));
    repeat (3) tick();
    check("wrap_level", wlevel, 4);
    check("wrap_full0", wfull, 0);

    // Reader pointer across the wrap leaves exactly DEPTH unread: full must assert
    drive(1'b0, 8'h00, gray(24));
    repeat (2) tick();
    check("wrapfull_level", wlevel, 16);
    check("wrapfull_e2_full", wfull, 0);
    tick();
    check("wrapfull_e3_full", wfull, 1);
    check("wrapfull_ready", bus.in_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
